// File: rtl/uart_bus_arbiter.sv
// Two-master Avalon-MM arbiter sharing one slave between the CPU (m0) and a UART host (m1).
// Define UART_ARB_ROUND_ROBIN_EN for round-robin tie breaking; fixed m0 priority otherwise.
module uart_bus_arbiter #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic                  clk,
    input  logic                  rst,

    input  logic                  m0_avn_read,
    input  logic                  m0_avn_write,
    input  logic [ADDR_W-1:0]     m0_avn_address,
    input  logic [DATA_W/8-1:0]   m0_avn_byte_enable,
    input  logic [DATA_W-1:0]     m0_avn_writedata,
    output logic [DATA_W-1:0]     m0_avn_readdata,
    output logic                  m0_avn_waitrequest,

    input  logic                  m1_avn_read,
    input  logic                  m1_avn_write,
    input  logic [ADDR_W-1:0]     m1_avn_address,
    input  logic [DATA_W/8-1:0]   m1_avn_byte_enable,
    input  logic [DATA_W-1:0]     m1_avn_writedata,
    output logic [DATA_W-1:0]     m1_avn_readdata,
    output logic                  m1_avn_waitrequest,

    output logic                  s_avn_read,
    output logic                  s_avn_write,
    output logic [ADDR_W-1:0]     s_avn_address,
    output logic [DATA_W/8-1:0]   s_avn_byte_enable,
    output logic [DATA_W-1:0]     s_avn_writedata,
    input  logic [DATA_W-1:0]     s_avn_readdata,
    input  logic                  s_avn_waitrequest,

    output logic [1:0]            grant
);

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        GNT0 = 2'b01,
        GNT1 = 2'b10
    } state_t;

    state_t state_q, state_d;
    logic   last_gnt_q, last_gnt_d;   // 0 = m0, 1 = m1
    logic   req0_s, req1_s;
    logic   pick1_s;

    assign req0_s = m0_avn_read | m0_avn_write;
    assign req1_s = m1_avn_read | m1_avn_write;

    // Winner selection when arbitrating out of IDLE
    always_comb begin
        pick1_s = 1'b0;
`ifdef UART_ARB_ROUND_ROBIN_EN
        if (req0_s && req1_s) begin
            pick1_s = ~last_gnt_q;
        end else begin
            pick1_s = req1_s;
        end
`else
        if (req0_s) begin
            pick1_s = 1'b0;
        end else begin
            pick1_s = req1_s;
        end
`endif
    end

    // State and last-grant registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            last_gnt_q <= 1'b1;
        end else begin
            state_q    <= state_d;
            last_gnt_q <= last_gnt_d;
        end
    end

    // Next-state logic: one transfer per grant, abandoned requests release the bus
    always_comb begin
        state_d    = state_q;
        last_gnt_d = last_gnt_q;
        case (state_q)
            IDLE: begin
                if (req0_s || req1_s) begin
                    state_d    = pick1_s ? GNT1 : GNT0;
                    last_gnt_d = pick1_s;
                end else begin
                    state_d = IDLE;
                end
            end
            GNT0: begin
                if (!req0_s || !s_avn_waitrequest) begin
                    state_d = IDLE;
                end else begin
                    state_d = GNT0;
                end
            end
            GNT1: begin
                if (!req1_s || !s_avn_waitrequest) begin
                    state_d = IDLE;
                end else begin
                    state_d = GNT1;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Slave request mux and master waitrequest steering
    always_comb begin
        s_avn_read         = 1'b0;
        s_avn_write        = 1'b0;
        s_avn_address      = {ADDR_W{1'b0}};
        s_avn_byte_enable  = {(DATA_W/8){1'b0}};
        s_avn_writedata    = {DATA_W{1'b0}};
        m0_avn_waitrequest = 1'b1;
        m1_avn_waitrequest = 1'b1;
        case (state_q)
            GNT0: begin
                s_avn_read         = m0_avn_read;
                s_avn_write        = m0_avn_write;
                s_avn_address      = m0_avn_address;
                s_avn_byte_enable  = m0_avn_byte_enable;
                s_avn_writedata    = m0_avn_writedata;
                m0_avn_waitrequest = s_avn_waitrequest;
            end
            GNT1: begin
                s_avn_read         = m1_avn_read;
                s_avn_write        = m1_avn_write;
                s_avn_address      = m1_avn_address;
                s_avn_byte_enable  = m1_avn_byte_enable;
                s_avn_writedata    = m1_avn_writedata;
                m1_avn_waitrequest = s_avn_waitrequest;
            end
            default: begin
                s_avn_read = 1'b0;
            end
        endcase
    end

    assign m0_avn_readdata = s_avn_readdata;
    assign m1_avn_readdata = s_avn_readdata;
    assign grant           = state_q;

endmodule

// File: tb/tb_uart_bus_arbiter.sv
// Directed table-driven bench for uart_bus_arbiter; expectations track UART_ARB_ROUND_ROBIN_EN.
module tb_uart_bus_arbiter;

    localparam int ADDR_W = 32;
    localparam int DATA_W = 32;

    logic              clk;
    logic              rst;
    logic              m0_avn_read, m0_avn_write;
    logic [ADDR_W-1:0] m0_avn_address;
    logic [3:0]        m0_avn_byte_enable;
    logic [DATA_W-1:0] m0_avn_writedata, m0_avn_readdata;
    logic              m0_avn_waitrequest;
    logic              m1_avn_read, m1_avn_write;
    logic [ADDR_W-1:0] m1_avn_address;
    logic [3:0]        m1_avn_byte_enable;
    logic [DATA_W-1:0] m1_avn_writedata, m1_avn_readdata;
    logic              m1_avn_waitrequest;
    logic              s_avn_read, s_avn_write;
    logic [ADDR_W-1:0] s_avn_address;
    logic [3:0]        s_avn_byte_enable;
    logic [DATA_W-1:0] s_avn_writedata, s_avn_readdata;
    logic              s_avn_waitrequest;
    logic [1:0]        grant;

    int n_vec  = 0;
    int n_fail = 0;

    uart_bus_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
        .clk(clk), .rst(rst),
        .m0_avn_read(m0_avn_read), .m0_avn_write(m0_avn_write),
        .m0_avn_address(m0_avn_address), .m0_avn_byte_enable(m0_avn_byte_enable),
        .m0_avn_writedata(m0_avn_writedata), .m0_avn_readdata(m0_avn_readdata),
        .m0_avn_waitrequest(m0_avn_waitrequest),
        .m1_avn_read(m1_avn_read), .m1_avn_write(m1_avn_write),
        .m1_avn_address(m1_avn_address), .m1_avn_byte_enable(m1_avn_byte_enable),
        .m1_avn_writedata(m1_avn_writedata), .m1_avn_readdata(m1_avn_readdata),
        .m1_avn_waitrequest(m1_avn_waitrequest),
        .s_avn_read(s_avn_read), .s_avn_write(s_avn_write),
        .s_avn_address(s_avn_address), .s_avn_byte_enable(s_avn_byte_enable),
        .s_avn_writedata(s_avn_writedata), .s_avn_readdata(s_avn_readdata),
        .s_avn_waitrequest(s_avn_waitrequest),
        .grant(grant)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic        rst;
        logic        m0r, m0w, m1r, m1w;
        logic        swait;
        logic [31:0] rdata;
        logic [1:0]  g;
        logic        sr, sw, w0, w1;
    } vec_t;

    vec_t vecs[22];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp, input int idx);
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s vec %0d: got %h expected %h", name, idx, act, exp);
        end
    endtask

    // Drive one vector after the falling edge, then compare outputs for this cycle
    task automatic apply(input vec_t v, input int idx);
        @(negedge clk);
        rst               = v.rst;
        m0_avn_read       = v.m0r;
        m0_avn_write      = v.m0w;
        m1_avn_read       = v.m1r;
        m1_avn_write      = v.m1w;
        s_avn_waitrequest = v.swait;
        s_avn_readdata    = v.rdata;
        #1;
        n_vec++;
        chk("grant",   {30'd0, grant},              {30'd0, v.g},  idx);
        chk("s_read",  {31'd0, s_avn_read},         {31'd0, v.sr}, idx);
        chk("s_write", {31'd0, s_avn_write},        {31'd0, v.sw}, idx);
        chk("m0_wait", {31'd0, m0_avn_waitrequest}, {31'd0, v.w0}, idx);
        chk("m1_wait", {31'd0, m1_avn_waitrequest}, {31'd0, v.w1}, idx);
        chk("m0_rdata", m0_avn_readdata, v.rdata, idx);
        chk("m1_rdata", m1_avn_readdata, v.rdata, idx);
        if (v.g == 2'b10) begin
            chk("s_addr",  s_avn_address,            32'h0000_0010, idx);
            chk("s_wdata", s_avn_writedata,          32'h0000_00A5, idx);
            chk("s_be",    {28'd0, s_avn_byte_enable}, 32'h1,       idx);
        end else if (v.g == 2'b01) begin
            chk("s_addr",  s_avn_address,            32'h0000_0100, idx);
            chk("s_wdata", s_avn_writedata,          32'hDEAD_BEEF, idx);
            chk("s_be",    {28'd0, s_avn_byte_enable}, 32'hF,       idx);
        end else begin
            chk("idle_g", {30'd0, grant}, 32'd0, idx);
        end
    endtask

    logic [1:0] exp_both[8];

    initial begin
        //            rst   m0r   m0w   m1r   m1w   swait rdata          g      sr    sw    w0    w1
        vecs[0]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0000_0000, 2'b00, 1'b0, 1'b0, 1'b1, 1'b1};
        vecs[1]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 32'h0000_0000, 2'b00, 1'b0, 1'b0, 1'b1, 1'b1};
        vecs[2]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 32'h0000_0000, 2'b10, 1'b0, 1'b1, 1'b1, 1'b0};
        vecs[3]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0000_0000, 2'b00, 1'b0, 1'b0, 1'b1, 1'b1};
        vecs[4]  = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 32'h0000_0000, 2'b00, 1'b0, 1'b0, 1'b1, 1'b1};
        vecs[5]  = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 32'h0000_0000, 2'b01, 1'b1, 1'b0, 1'b1, 1'b1};
        vecs[6]  = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 32'h0000_0000, 2'b01, 1'b1, 1'b0, 1'b1, 1'b1};
        vecs[7]  = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 32'h0000_0000, 2'b01, 1'b1, 1'b0, 1'b1, 1'b1};
        vecs[8]  = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h1234_5678, 2'b01, 1'b1, 1'b0, 1'b0, 1'b1};
        vecs[9]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0000_0000, 2'b00, 1'b0, 1'b0, 1'b1, 1'b1};
        vecs[10] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 32'h0000_0000, 2'b00, 1'b0, 1'b0, 1'b1, 1'b1};
        vecs[11] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 32'h0000_0000, 2'b01, 1'b1, 1'b0, 1'b1, 1'b1};
        vecs[12] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 32'h0000_0000, 2'b01, 1'b0, 1'b0, 1'b1, 1'b1};
        vecs[13] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 32'h0000_0000, 2'b00, 1'b0, 1'b0, 1'b1, 1'b1};
        vecs[14] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 32'h0000_0000, 2'b10, 1'b0, 1'b1, 1'b1, 1'b1};
        vecs[15] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 32'h0000_0000, 2'b10, 1'b0, 1'b1, 1'b1, 1'b1};
        vecs[16] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 32'h0000_0000, 2'b00, 1'b0, 1'b0, 1'b1, 1'b1};
        vecs[17] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 32'h0000_0000, 2'b10, 1'b0, 1'b1, 1'b1, 1'b0};
        vecs[18] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0000_0000, 2'b00, 1'b0, 1'b0, 1'b1, 1'b1};
        vecs[19] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0000_0000, 2'b00, 1'b0, 1'b0, 1'b1, 1'b1};
        vecs[20] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0000_0000, 2'b01, 1'b1, 1'b1, 1'b0, 1'b1};
        vecs[21] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0000_0000, 2'b00, 1'b0, 1'b0, 1'b1, 1'b1};

`ifdef UART_ARB_ROUND_ROBIN_EN
        exp_both = '{2'b00, 2'b01, 2'b00, 2'b10, 2'b00, 2'b01, 2'b00, 2'b10};
`else
        exp_both = '{2'b00, 2'b01, 2'b00, 2'b01, 2'b00, 2'b01, 2'b00, 2'b01};
`endif

        rst                = 1'b1;
        m0_avn_read        = 1'b0;
        m0_avn_write       = 1'b0;
        m1_avn_read        = 1'b0;
        m1_avn_write       = 1'b0;
        m0_avn_address     = 32'h0000_0100;
        m0_avn_byte_enable = 4'hF;
        m0_avn_writedata   = 32'hDEAD_BEEF;
        m1_avn_address     = 32'h0000_0010;
        m1_avn_byte_enable = 4'h1;
        m1_avn_writedata   = 32'h0000_00A5;
        s_avn_readdata     = 32'h0;
        s_avn_waitrequest  = 1'b0;
        repeat (2) @(posedge clk);

        for (int i = 0; i < 22; i++) begin
            apply(vecs[i], i);
        end

        // Both masters request continuously right after a reset pulse
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst               = 1'b0;
        m0_avn_read       = 1'b1;
        m0_avn_write      = 1'b0;
        m1_avn_read       = 1'b0;
        m1_avn_write      = 1'b1;
        s_avn_waitrequest = 1'b0;
        for (int k = 0; k < 8; k++) begin
            if (k > 0) @(negedge clk);
            #1;
            n_vec++;
            chk("rr_grant", {30'd0, grant}, {30'd0, exp_both[k]}, 100 + k);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
